// File: rtl/adc_scan_seq.sv
// Scans the CH_MASK channels of an ADC128S022-class SPI ADC, averages 2^AVG_LOG2 conversions
// per channel and publishes results; define ADC_SCAN_THRESH_EN to add THRESH and line_bits.
module adc_scan_seq #(
  parameter logic [7:0] CH_MASK    = 8'b0000_0111,
  parameter int         AVG_LOG2   = 0,
  parameter int         SCK_HALF   = 1,
  parameter int         CS_GAP     = 2,
  parameter bit         CONTINUOUS = 1'b1
`ifdef ADC_SCAN_THRESH_EN
  ,
  parameter logic [11:0] THRESH    = 12'd1000
`endif
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic        busy,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic [95:0] ch_values,
  output logic        scan_done
`ifdef ADC_SCAN_THRESH_EN
  ,
  output logic [7:0]  line_bits
`endif
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_FRAME  = 2'd1;
  localparam logic [1:0]  S_GAP    = 2'd2;
  localparam int          ACC_W    = 12 + AVG_LOG2;
  localparam logic [2:0]  REP_LAST = 3'((1 << AVG_LOG2) - 1);
  localparam logic [15:0] HALF_RLD = 16'(SCK_HALF - 1);
  localparam logic [15:0] GAP_RLD  = 16'(CS_GAP - 1);

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) if (m[k]) r = 3'(k);
    return r;
  endfunction

  function automatic logic [2:0] highest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (m[k]) r = 3'(k);
    return r;
  endfunction

  localparam logic [2:0] FIRST_CH = lowest_ch(CH_MASK);
  localparam logic [2:0] LAST_CH  = highest_ch(CH_MASK);

  // Next enabled channel above c, wrapping to the first one.
  function automatic logic [2:0] next_ch(input logic [2:0] c);
    logic [2:0] r;
    r = FIRST_CH;
    for (int k = 7; k >= 0; k--) if (CH_MASK[k] && (k > int'(c))) r = 3'(k);
    return r;
  endfunction

  function automatic logic din_for(input logic [3:0] n, input logic [2:0] a);
    case (n)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic             cs_n_q, cs_n_d, sck_q, sck_d, din_q, din_d;
  logic             busy_q, busy_d, phase_q, phase_d, last_q, last_d;
  logic [15:0]      half_q, half_d, gap_q, gap_d;
  logic [3:0]       bit_q, bit_d;
  logic [10:0]      shift_q, shift_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       addr_ch_q, addr_ch_d, addr_rep_q, addr_rep_d;
  logic [2:0]       data_ch_q, data_ch_d, data_rep_q, data_rep_d;
  logic             data_vld_q, data_vld_d;
  logic             sv_q, sv_d, done_q, done_d;
  logic [2:0]       sch_q, sch_d;
  logic [11:0]      sdat_q, sdat_d;
  logic [95:0]      chv_q, chv_d;
`ifdef ADC_SCAN_THRESH_EN
  logic [7:0]       lb_q, lb_d;
`endif
  logic             start_frame;

  wire [11:0]      word      = {shift_q, adc_dout};
  wire [ACC_W-1:0] acc_sum   = ((data_rep_q == 3'd0) ? '0 : acc_q) + ACC_W'(word);
  wire [11:0]      pub_val   = 12'(acc_sum >> AVG_LOG2);
  wire             data_last = data_vld_q && (data_ch_q == LAST_CH) && (data_rep_q == REP_LAST);

  always_comb begin
    state_d = state_q; cs_n_d = cs_n_q; sck_d = sck_q; din_d = din_q;
    busy_d = busy_q; phase_d = phase_q; last_d = last_q;
    half_d = half_q; gap_d = gap_q; bit_d = bit_q; shift_d = shift_q; acc_d = acc_q;
    addr_ch_d = addr_ch_q; addr_rep_d = addr_rep_q;
    data_ch_d = data_ch_q; data_rep_d = data_rep_q; data_vld_d = data_vld_q;
    sv_d = 1'b0; done_d = 1'b0; sch_d = sch_q; sdat_d = sdat_q; chv_d = chv_q;
`ifdef ADC_SCAN_THRESH_EN
    lb_d = lb_q;
`endif
    start_frame = 1'b0;
    case (state_q)
      S_IDLE: if (CONTINUOUS || start) begin
        busy_d      = 1'b1;
        start_frame = 1'b1;
      end
      S_FRAME: begin
        if (half_q != 16'd0) begin
          half_d = half_q - 16'd1;
        end else if (!phase_q) begin
          // SCK rising: sample the ADC, and on bit 15 fold the finished word in.
          sck_d   = 1'b1;
          phase_d = 1'b1;
          half_d  = HALF_RLD;
          shift_d = {shift_q[9:0], adc_dout};
          if (bit_q == 4'd15 && data_vld_q) begin
            if (data_rep_q == REP_LAST) begin
              sv_d   = 1'b1;
              sch_d  = data_ch_q;
              sdat_d = pub_val;
              chv_d[int'(data_ch_q)*12 +: 12] = pub_val;
`ifdef ADC_SCAN_THRESH_EN
              lb_d[data_ch_q] = (pub_val >= THRESH);
`endif
              if (data_ch_q == LAST_CH) begin
                done_d = 1'b1;
                if (!CONTINUOUS) busy_d = 1'b0;
              end
            end else begin
              acc_d = acc_sum;
            end
          end
        end else if (bit_q != 4'd15) begin
          sck_d   = 1'b0;
          phase_d = 1'b0;
          half_d  = HALF_RLD;
          bit_d   = bit_q + 4'd1;
          din_d   = din_for(bit_q + 4'd1, addr_ch_q);
        end else begin
          cs_n_d  = 1'b1;
          din_d   = 1'b0;
          state_d = S_GAP;
          gap_d   = GAP_RLD;
          if (!CONTINUOUS && data_last) begin
            last_d     = 1'b1;
            data_vld_d = 1'b0;
            addr_ch_d  = FIRST_CH;
            addr_rep_d = 3'd0;
          end else begin
            data_ch_d  = addr_ch_q;
            data_rep_d = addr_rep_q;
            data_vld_d = 1'b1;
            if (addr_rep_q == REP_LAST) begin
              addr_rep_d = 3'd0;
              addr_ch_d  = next_ch(addr_ch_q);
            end else begin
              addr_rep_d = addr_rep_q + 3'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else if (last_q) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else begin
          start_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_frame) begin
      state_d = S_FRAME; cs_n_d = 1'b0; sck_d = 1'b0; din_d = 1'b0;
      bit_d = 4'd0; phase_d = 1'b0; half_d = HALF_RLD;
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; cs_n_q <= 1'b1; sck_q <= 1'b1; din_q <= 1'b0;
      busy_q <= 1'b0; phase_q <= 1'b0; last_q <= 1'b0;
      half_q <= '0; gap_q <= '0; bit_q <= '0; shift_q <= '0; acc_q <= '0;
      addr_ch_q <= FIRST_CH; addr_rep_q <= '0;
      data_ch_q <= '0; data_rep_q <= '0; data_vld_q <= 1'b0;
      sv_q <= 1'b0; done_q <= 1'b0; sch_q <= '0; sdat_q <= '0; chv_q <= '0;
`ifdef ADC_SCAN_THRESH_EN
      lb_q <= '0;
`endif
    end else begin
      state_q <= state_d; cs_n_q <= cs_n_d; sck_q <= sck_d; din_q <= din_d;
      busy_q <= busy_d; phase_q <= phase_d; last_q <= last_d;
      half_q <= half_d; gap_q <= gap_d; bit_q <= bit_d; shift_q <= shift_d; acc_q <= acc_d;
      addr_ch_q <= addr_ch_d; addr_rep_q <= addr_rep_d;
      data_ch_q <= data_ch_d; data_rep_q <= data_rep_d; data_vld_q <= data_vld_d;
      sv_q <= sv_d; done_q <= done_d; sch_q <= sch_d; sdat_q <= sdat_d; chv_q <= chv_d;
`ifdef ADC_SCAN_THRESH_EN
      lb_q <= lb_d;
`endif
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sck      = sck_q;
  assign adc_din      = din_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign sample_data  = sdat_q;
  assign ch_values    = chv_q;
  assign scan_done    = done_q;
`ifdef ADC_SCAN_THRESH_EN
  assign line_bits    = lb_q;
`endif

endmodule

// File: tb/tb_adc_scan_seq.sv
// Bench for adc_scan_seq: three instances (default continuous, averaging single-shot,
// default-mask single-shot) each driven by a behavioural ADC128S022 model.
module tb_adc_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v   = 3'b000;
  logic [2:0] start_v = 3'b000;
  logic [2:0] dout_v  = 3'b000;
  wire  [2:0] cs_n_v, sck_v, din_v, busy_v, sv_v, done_v;
  wire  [2:0]  sch  [3];
  wire  [11:0] sdat [3];
  wire  [95:0] chv  [3];
`ifdef ADC_SCAN_THRESH_EN
  wire  [7:0]  lb   [3];
`endif

  int errs   = 0;
  int checks = 0;

  adc_scan_seq u_def (
    .clk_3125KHz(clk), .rst_n(rst_v[0]), .start(start_v[0]), .adc_dout(dout_v[0]),
    .adc_cs_n(cs_n_v[0]), .adc_sck(sck_v[0]), .adc_din(din_v[0]), .busy(busy_v[0]),
    .sample_valid(sv_v[0]), .sample_ch(sch[0]), .sample_data(sdat[0]),
    .ch_values(chv[0]), .scan_done(done_v[0])
`ifdef ADC_SCAN_THRESH_EN
    , .line_bits(lb[0])
`endif
  );

  adc_scan_seq #(.CH_MASK(8'h10), .AVG_LOG2(2), .CONTINUOUS(1'b0)) u_avg (
    .clk_3125KHz(clk), .rst_n(rst_v[1]), .start(start_v[1]), .adc_dout(dout_v[1]),
    .adc_cs_n(cs_n_v[1]), .adc_sck(sck_v[1]), .adc_din(din_v[1]), .busy(busy_v[1]),
    .sample_valid(sv_v[1]), .sample_ch(sch[1]), .sample_data(sdat[1]),
    .ch_values(chv[1]), .scan_done(done_v[1])
`ifdef ADC_SCAN_THRESH_EN
    , .line_bits(lb[1])
`endif
  );

  adc_scan_seq #(.CONTINUOUS(1'b0)) u_ss (
    .clk_3125KHz(clk), .rst_n(rst_v[2]), .start(start_v[2]), .adc_dout(dout_v[2]),
    .adc_cs_n(cs_n_v[2]), .adc_sck(sck_v[2]), .adc_din(din_v[2]), .busy(busy_v[2]),
    .sample_valid(sv_v[2]), .sample_ch(sch[2]), .sample_data(sdat[2]),
    .ch_values(chv[2]), .scan_done(done_v[2])
`ifdef ADC_SCAN_THRESH_EN
    , .line_bits(lb[2])
`endif
  );

  // ---------------- ADC model ----------------
  int         m_cnt   [3] = '{default: 0};
  logic [2:0] m_sh    [3] = '{default: 3'd0};
  logic [2:0] m_cur   [3] = '{default: 3'd0};
  logic [11:0] m_word [3] = '{default: 12'd0};
  logic       pcs     [3] = '{default: 1'b1};
  logic       psck    [3] = '{default: 1'b1};
  logic       pdin    [3] = '{default: 1'b0};
  int         frames  [3] = '{default: 0};
  int         gap_len [3] = '{default: 0};
  int         k4 = 0;
  int         falls_q [$];
  int         gaps_q  [$];
  logic [2:0] addr_q  [$];
  int         din_bad = 0;
  int         sck_gap_bad = 0;

  function automatic logic [11:0] conv_val(input int inst, input logic [2:0] ch, input int k);
    if (inst == 0) begin
      case (ch)
        3'd0:    return 12'h0A5;
        3'd1:    return 12'h3FF;
        3'd2:    return 12'hFFF;
        default: return 12'h000;
      endcase
    end else if (inst == 1) begin
      return (ch == 3'd4) ? 12'(100 + k) : 12'h000;
    end else begin
      case (ch)
        3'd0:    return 12'd999;
        3'd1:    return 12'd1000;
        3'd2:    return 12'd4095;
        default: return 12'h000;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!pcs[i] && cs_n_v[i]) begin
        m_cur[i]   = m_sh[i];
        gap_len[i] = 0;
        if (i == 0) begin
          falls_q.push_back(m_cnt[0]);
          addr_q.push_back(m_sh[0]);
        end
      end
      if (pcs[i] && !cs_n_v[i]) begin
        if (i == 0 && frames[0] > 0) gaps_q.push_back(gap_len[0]);
        frames[i] = frames[i] + 1;
        m_cnt[i]  = 0;
        m_word[i] = conv_val(i, m_cur[i], k4);
        if (i == 1 && m_cur[i] == 3'd4) k4 = k4 + 1;
      end
      if (!cs_n_v[i]) begin
        if (psck[i] && !sck_v[i]) begin
          dout_v[i] <= (m_cnt[i] < 4) ? 1'b0 : m_word[i][15 - m_cnt[i]];
          m_cnt[i] = m_cnt[i] + 1;
        end
        if (!psck[i] && sck_v[i] && m_cnt[i] >= 3 && m_cnt[i] <= 5)
          m_sh[i] = {m_sh[i][1:0], din_v[i]};
        if (i == 0 && !pcs[0] && din_v[0] !== pdin[0] && !(psck[0] && !sck_v[0]))
          din_bad = din_bad + 1;
      end else begin
        gap_len[i] = gap_len[i] + 1;
        if (i == 0 && !sck_v[0]) sck_gap_bad = sck_gap_bad + 1;
      end
      pcs[i]  = cs_n_v[i];
      psck[i] = sck_v[i];
      pdin[i] = din_v[i];
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cs_n_v[i], sck_v[i], din_v[i], busy_v[i], sv_v[i], done_v[i]} !== 6'b110000) begin
        errs++;
        $display("FAIL reset_ctl inst%0d got %b want 110000", i,
                 {cs_n_v[i], sck_v[i], din_v[i], busy_v[i], sv_v[i], done_v[i]});
      end
      checks++;
      if (sch[i] !== 3'd0 || sdat[i] !== 12'd0) begin
        errs++;
        $display("FAIL reset_sample inst%0d got ch=%0d data=%h want 0/000", i, sch[i], sdat[i]);
      end
      checks++;
      if (chv[i] !== 96'd0) begin
        errs++;
        $display("FAIL reset_chv inst%0d got %h want 0", i, chv[i]);
      end
    end
  endtask

  task automatic test_default_scan;
    logic [2:0]  ch_got [3];
    logic [11:0] d_got  [3];
    logic        dn_got [3];
    logic [11:0] exp_d  [3];
    int          fr3;
    int          np;
    int          c;
    exp_d = '{12'h0A5, 12'h3FF, 12'hFFF};
    rst_v[0] = 1'b1;
    tick();
    checks++;
    if (busy_v[0] !== 1'b1 || cs_n_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL cont_start got busy=%b cs_n=%b want 1/0", busy_v[0], cs_n_v[0]);
    end
    np = 0; c = 0; fr3 = 0;
    while (np < 3 && c < 3000) begin
      tick();
      c++;
      if (sv_v[0]) begin
        ch_got[np] = sch[0]; d_got[np] = sdat[0]; dn_got[np] = done_v[0];
        if (np == 2) fr3 = frames[0];
        np++;
      end
    end
    checks++;
    if (np != 3) begin
      errs++;
      $display("FAIL scan1_timeout got %0d pulses want 3", np);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ch_got[k] !== 3'(k) || d_got[k] !== exp_d[k] || dn_got[k] !== (k == 2)) begin
          errs++;
          $display("FAIL scan1_pulse%0d got ch=%0d data=%h done=%b want ch=%0d data=%h done=%b",
                   k, ch_got[k], d_got[k], dn_got[k], k, exp_d[k], (k == 2));
        end
      end
      checks++;
      if (fr3 != 4) begin
        errs++;
        $display("FAIL scan1_frames got %0d want 4", fr3);
      end
    end
    checks++;
    if (chv[0][35:0] !== 36'hFFF3FF0A5 || chv[0][95:36] !== 60'd0) begin
      errs++;
      $display("FAIL ch_values got %h want 000...FFF3FF0A5", chv[0]);
    end
    c = 0;
    do begin tick(); c++; end while (!done_v[0] && c < 3000);
    checks++;
    if (!done_v[0] || frames[0] != 7) begin
      errs++;
      $display("FAIL scan2_frames got done=%b frames=%0d want 1/7", done_v[0], frames[0]);
    end
  endtask

  task automatic test_bus;
    logic [2:0] exp_a [4];
    exp_a = '{3'd0, 3'd1, 3'd2, 3'd0};
    checks++;
    if (addr_q.size() < 6 || gaps_q.size() < 5) begin
      errs++;
      $display("FAIL bus_log got %0d frames %0d gaps want >=6/>=5", addr_q.size(), gaps_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (addr_q[k] !== exp_a[k]) begin
          errs++;
          $display("FAIL din_addr frame%0d got %0d want %0d", k, addr_q[k], exp_a[k]);
        end
      end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (falls_q[k] != 16) begin
          errs++;
          $display("FAIL sck_falls frame%0d got %0d want 16", k, falls_q[k]);
        end
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gaps_q[k] != 2) begin
          errs++;
          $display("FAIL cs_gap gap%0d got %0d want 2", k, gaps_q[k]);
        end
      end
    end
    checks++;
    if (din_bad != 0 || sck_gap_bad != 0) begin
      errs++;
      $display("FAIL bus_rules got din_bad=%0d sck_low_in_gap=%0d want 0/0", din_bad, sck_gap_bad);
    end
  endtask

  task automatic test_avg;
    int c;
    rst_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    checks++;
    if (busy_v[1] !== 1'b1) begin
      errs++;
      $display("FAIL avg_busy got %b want 1", busy_v[1]);
    end
    c = 0;
    do begin tick(); c++; end while (!sv_v[1] && c < 3000);
    checks++;
    if (!sv_v[1] || sch[1] !== 3'd4 || sdat[1] !== 12'd101 || done_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
      errs++;
      $display("FAIL avg_result got vld=%b ch=%0d data=%0d done=%b busy=%b want 1/4/101/1/0",
               sv_v[1], sch[1], sdat[1], done_v[1], busy_v[1]);
    end
    checks++;
    if (chv[1] !== (96'd101 << 48)) begin
      errs++;
      $display("FAIL avg_chv got %h want slice4=101 rest 0", chv[1]);
    end
    repeat (200) tick();
    checks++;
    if (frames[1] != 5 || busy_v[1] !== 1'b0) begin
      errs++;
      $display("FAIL avg_frames got frames=%0d busy=%b want 5/0", frames[1], busy_v[1]);
    end
  endtask

  task automatic test_single_shot;
    int c;
    rst_v[2] = 1'b1;
    repeat (20) tick();
    checks++;
    if (frames[2] != 0 || busy_v[2] !== 1'b0 || cs_n_v[2] !== 1'b1) begin
      errs++;
      $display("FAIL ss_idle got frames=%0d busy=%b cs_n=%b want 0/0/1", frames[2], busy_v[2], cs_n_v[2]);
    end
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    checks++;
    if (busy_v[2] !== 1'b1) begin
      errs++;
      $display("FAIL ss_busy_rise got %b want 1", busy_v[2]);
    end
    repeat (40) tick();
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    c = 0;
    do begin tick(); c++; end while (!done_v[2] && c < 3000);
    checks++;
    if (!done_v[2] || busy_v[2] !== 1'b0 || sch[2] !== 3'd2 || sdat[2] !== 12'd4095) begin
      errs++;
      $display("FAIL ss_done got done=%b busy=%b ch=%0d data=%0d want 1/0/2/4095",
               done_v[2], busy_v[2], sch[2], sdat[2]);
    end
    checks++;
    if (chv[2][35:0] !== {12'd4095, 12'd1000, 12'd999} || frames[2] != 4) begin
      errs++;
      $display("FAIL ss_values got chv=%h frames=%0d want FFF3E83E7/4", chv[2][35:0], frames[2]);
    end
`ifdef ADC_SCAN_THRESH_EN
    checks++;
    if (lb[2] !== 8'b0000_0110 || lb[1] !== 8'b0000_0000) begin
      errs++;
      $display("FAIL line_bits got ss=%b avg=%b want 00000110/00000000", lb[2], lb[1]);
    end
`endif
    repeat (300) tick();
    checks++;
    if (frames[2] != 4 || busy_v[2] !== 1'b0) begin
      errs++;
      $display("FAIL ss_quiet got frames=%0d busy=%b want 4/0", frames[2], busy_v[2]);
    end
  endtask

  task automatic test_reset_midframe;
    int c;
    int f0;
    c = 0;
    do begin tick(); c++; end while (!(!cs_n_v[0] && m_cnt[0] == 10) && c < 500);
    checks++;
    if (cs_n_v[0] || m_cnt[0] != 10) begin
      errs++;
      $display("FAIL bit9_timeout got cs_n=%b falls=%0d want 0/10", cs_n_v[0], m_cnt[0]);
    end
    rst_v[0] = 1'b0;
    #1;
    checks++;
    if ({cs_n_v[0], sck_v[0], din_v[0], busy_v[0], sv_v[0], done_v[0]} !== 6'b110000 ||
        sch[0] !== 3'd0 || sdat[0] !== 12'd0 || chv[0] !== 96'd0) begin
      errs++;
      $display("FAIL midframe_reset got ctl=%b ch=%0d data=%h chv=%h want 110000/0/000/0",
               {cs_n_v[0], sck_v[0], din_v[0], busy_v[0], sv_v[0], done_v[0]}, sch[0], sdat[0], chv[0]);
    end
    repeat (3) tick();
    f0 = frames[0];
    rst_v[0] = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!sv_v[0] && c < 3000);
    checks++;
    if (!sv_v[0] || (frames[0] - f0) != 2 || sch[0] !== 3'd0 || sdat[0] !== 12'h0A5) begin
      errs++;
      $display("FAIL post_reset_first got vld=%b frames=%0d ch=%0d data=%h want 1/2/0/0A5",
               sv_v[0], frames[0] - f0, sch[0], sdat[0]);
    end
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_bus();
    test_avg();
    test_single_shot();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_seq.md
Name: adc_scan_seq

Overview:
Parametrised successor to the fixed 3-channel ADC controller that feeds line following. Scans any subset of the 8 inputs of the ADC128S022-class SPI ADC, averages 2^AVG_LOG2 conversions per channel, and publishes each result with a valid pulse plus a latched per-channel bus. Sits between the ADC pins and Line_Following / fault logic, and supports continuous or single-shot scan modes.

Parameters:
CH_MASK, 8'b0000_0111, bit i=1 -> channel i is scanned; scanned in ascending index order; 0 is illegal.
AVG_LOG2, 0, conversions averaged per channel = 2^AVG_LOG2; range 0..3.
SCK_HALF, 1, clk_3125KHz cycles per SCK half-period; must be >=1.
CS_GAP, 2, clk cycles adc_cs_n held high between frames; must be >=1.
CONTINUOUS, 1, 1 = free-running scan; 0 = one scan per start pulse.

Ports:
clk_3125KHz  in  1  block clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-shot trigger, 1-cycle pulse; ignored when CONTINUOUS=1 or busy=1
adc_dout  in  1  ADC serial data
adc_cs_n  out  1  ADC chip select, active low
adc_sck  out  1  ADC serial clock, idle high
adc_din  out  1  ADC address bit stream
busy  out  1  high while a scan is in progress
sample_valid  out  1  1-cycle pulse when sample_data is new
sample_ch  out  3  channel of sample_data
sample_data  out  12  averaged result
ch_values  out  96  latest result per channel, ch i at [12i+11:12i]
scan_done  out  1  1-cycle pulse after the last enabled channel is published

Behaviour:
- Reset: adc_cs_n=1, adc_sck=1, adc_din=0, busy=0, sample_valid=0, sample_ch=0, sample_data=0, ch_values=0, scan_done=0, FSM=IDLE. Async assert, sync deassert, same clock.
- FSM: IDLE -> FRAME (16 SCK periods, cs_n low) -> GAP (CS_GAP cycles, cs_n high) -> FRAME ... -> IDLE.
- IDLE exit: one cycle after reset release if CONTINUOUS=1; otherwise on start.
- Frame bit n=0..15: SCK falls at the start of the bit; adc_din changes only on SCK falls and is held for the whole bit. adc_dout is sampled on the clk cycle in which SCK rises.
- adc_din: bits 2,3,4 carry ADD2,ADD1,ADD0 of the channel requested in this frame; 0 on all other bits.
- Pipeline: data in frame k is the conversion addressed in frame k-1. Bits 4..15 are data, MSB first. The first frame of each scan is a priming frame; its data is discarded.
- Slot sequence per scan: each enabled channel repeated 2^AVG_LOG2 times consecutively, ascending index. Frames per scan = popcount(CH_MASK)*2^AVG_LOG2 + 1. The extra last frame re-addresses the first channel and only returns data.
- Averaging: accumulator is 12+AVG_LOG2 bits and is cleared at each channel's first slot. result = acc >> AVG_LOG2, truncating.
- Publish: sample_valid pulses the cycle after the last data bit of a channel's final slot. sample_ch, sample_data and the ch_values slice update in that same cycle and hold until the next publish.
- scan_done coincides with the sample_valid of the last channel.
- Disabled channels are never addressed; their ch_values slices stay 0.
- CONTINUOUS=1: the next scan starts in the frame after GAP. Its priming frame is replaced by the previous scan's trailing frame, so there are no dead frames. busy stays 1.
- CONTINUOUS=0: busy rises the cycle after start and falls with scan_done. start while busy=1 is dropped.
- Reset mid-frame: all state is lost immediately; cs_n=1, and no partial result is published.

Optional Feature:
Macro ADC_SCAN_THRESH_EN.
- Defined: adds parameter THRESH (default 12'd1000) and output line_bits[7:0]. line_bits[i] = (ch_values slice i >= THRESH), registered and updated on the same cycle as the slice; disabled channels read 0; reset value 0.
- Undefined: no THRESH parameter, no line_bits port, no comparators.

Test Plan:
- Defaults, ADC model returns 12'h0A5 on ch0, 12'h3FF on ch1, 12'hFFF on ch2 -> sample_valid with ch 0,1,2 in order; ch_values = {12'hFFF,12'h3FF,12'h0A5} at the bits [35:0]; scan_done on the ch2 pulse; 4 frames in the first scan, 3 per scan thereafter.
- Bus check, defaults -> adc_din shows address 000/001/010/000 in bits 2-4; SCK idle high with cs_n high for exactly 2 cycles between frames; 16 SCK falls per frame.
- AVG_LOG2=2, CH_MASK=8'h10, model returns 100,101,102,103 -> sample_ch=4, sample_data=101 (406>>2); 5 frames.
- CONTINUOUS=0: start pulse -> busy=1 next cycle; a second start mid-scan is ignored; busy falls with scan_done; no frames until the next start.
- Assert rst_n low at frame bit 9 -> same cycle: cs_n=1, sck=1, outputs cleared; after release, a full priming frame precedes any sample_valid.
- ADC_SCAN_THRESH_EN, THRESH=1000, ch values 999/1000/4095 -> line_bits=8'b0000_0110.
